rs232_block_tx: RTL and testbench



---
 rtl/rs232_block_tx.sv | 173 +++++++++++++++++
 tb/tb_rs232_block_tx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rs232_block_tx.sv
// RS-232 block transmitter: sends an 8*NUM_BYTES-bit block as NUM_BYTES UART frames, byte 0 first, LSB first.
// Define RS232_TX_PARITY_EN to add an even-parity bit to each frame (8E1 instead of 8N1).
//
// state     | meaning
// IDLE      | line high, waiting for tx_start
// START_BIT | line low for one bit time
// DATA_BITS | shift[0] on the line, 8 bits LSB first
// PARITY    | even parity of the current byte (RS232_TX_PARITY_EN only)
// STOP_BIT  | line high for STOP_BITS bit times
// NEXT      | one extra high cycle between frames; advance byte or finish
// DONE      | tx_done pulse, busy drops, back to IDLE
module rs232_block_tx #(
  parameter int CLKS_PER_BIT = 22,
  parameter int NUM_BYTES    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*NUM_BYTES-1:0] data_in,
  input  logic                   tx_start,
  output logic                   tx_out,
  output logic                   busy,
  output logic                   tx_done
);

  localparam int BYTE_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [12:0]       BIT_LAST  = 13'(CLKS_PER_BIT - 1);
  localparam logic [12:0]       STOP_LAST = 13'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

`ifdef RS232_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START_BIT, DATA_BITS, PARITY, STOP_BIT, NEXT, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START_BIT, DATA_BITS, STOP_BIT, NEXT, DONE
  } state_t;
`endif

  state_t                 state, state_n;
  logic [12:0]            clk_cnt, clk_cnt_n;
  logic [2:0]             bit_cnt, bit_cnt_n;
  logic [BYTE_W-1:0]      byte_cnt, byte_cnt_n;
  logic [8*NUM_BYTES-1:0] shift, shift_n;
  logic                   tx_n, busy_n, done_n;
`ifdef RS232_TX_PARITY_EN
  logic                   par, par_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shift    <= '0;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
`ifdef RS232_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      clk_cnt  <= clk_cnt_n;
      bit_cnt  <= bit_cnt_n;
      byte_cnt <= byte_cnt_n;
      shift    <= shift_n;
      tx_out   <= tx_n;
      busy     <= busy_n;
      tx_done  <= done_n;
`ifdef RS232_TX_PARITY_EN
      par      <= par_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    clk_cnt_n  = clk_cnt + 13'd1;
    bit_cnt_n  = bit_cnt;
    byte_cnt_n = byte_cnt;
    shift_n    = shift;
`ifdef RS232_TX_PARITY_EN
    par_n      = par;
`endif
    case (state)
      IDLE: begin
        clk_cnt_n = '0;
        if (tx_start) begin
          shift_n    = data_in;
          byte_cnt_n = '0;
          bit_cnt_n  = '0;
          state_n    = START_BIT;
        end
      end
      START_BIT: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_n = '0;
          bit_cnt_n = '0;
`ifdef RS232_TX_PARITY_EN
          par_n     = 1'b0;
`endif
          state_n   = DATA_BITS;
        end
      end
      DATA_BITS: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_n = '0;
          shift_n   = shift >> 1;
          bit_cnt_n = bit_cnt + 3'd1;
`ifdef RS232_TX_PARITY_EN
          par_n     = par ^ shift[0];
          if (bit_cnt == 3'd7) state_n = PARITY;
`else
          if (bit_cnt == 3'd7) state_n = STOP_BIT;
`endif
        end
      end
`ifdef RS232_TX_PARITY_EN
      PARITY: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_n = '0;
          state_n   = STOP_BIT;
        end
      end
`endif
      STOP_BIT: begin
        if (clk_cnt == STOP_LAST) begin
          clk_cnt_n = '0;
          state_n   = NEXT;
        end
      end
      NEXT: begin
        clk_cnt_n = '0;
        if (byte_cnt == BYTE_LAST) begin
          state_n = DONE;
        end else begin
          byte_cnt_n = byte_cnt + 1'b1;
          state_n    = START_BIT;
        end
      end
      DONE: begin
        clk_cnt_n = '0;
        state_n   = IDLE;
      end
      default: begin
        clk_cnt_n = '0;
        state_n   = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the registers line up with it.
    tx_n   = 1'b1;
    busy_n = 1'b1;
    done_n = 1'b0;
    case (state_n)
      IDLE:      busy_n = 1'b0;
      START_BIT: tx_n   = 1'b0;
      DATA_BITS: tx_n   = shift_n[0];
`ifdef RS232_TX_PARITY_EN
      PARITY:    tx_n   = par_n;
`endif
      DONE: begin
        busy_n = 1'b0;
        done_n = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rs232_block_tx.sv
// Scoreboard bench for rs232_block_tx: stimulus queues expected blocks, a monitor checks the serial line cycle by cycle.
module tb_rs232_block_tx;

  localparam int CPB = 22;
  localparam int NB  = 8;
`ifdef RS232_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FR  = (10 + PAR) * CPB + 1;
  localparam int BLK = NB * FR;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_start = 1'b0;
  logic [63:0] data_in = '0;
  logic        tx_out, busy, tx_done;

  int cyc = 0;
  int passed = 0;
  int total = 0;

  typedef struct {
    logic [63:0] data;
    int          start;
  } exp_t;
  exp_t q[$];

  bit   mon_active = 1'b0;
  exp_t mon_e;
  int   mon_c = 0;
  int   mon_bad = 0;
  int   mon_busy_bad = 0;

  rs232_block_tx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .tx_start(tx_start),
    .tx_out(tx_out), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected line level c cycles after busy rises: start, 8 data LSB first, [parity], stop, one gap cycle.
  function automatic logic exp_bit(input logic [63:0] d, input int c);
    int k, r, b;
    logic [7:0] by;
    k  = c / FR;
    r  = c % FR;
    by = 8'(d >> (8 * k));
    if (r == FR - 1) return 1'b1;
    b = r / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return by[b-1];
    if (PAR == 1 && b == 9) return ^by;
    return 1'b1;
  endfunction

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_active = 1'b0;
        continue;
      end
      if (!mon_active && busy && q.size() > 0) begin
        mon_e        = q.pop_front();
        mon_active   = 1'b1;
        mon_c        = 0;
        mon_bad      = 0;
        mon_busy_bad = 0;
        check("start cycle", cyc, mon_e.start);
      end
      if (mon_active) begin
        if (mon_c < BLK) begin
          if (tx_out !== exp_bit(mon_e.data, mon_c)) mon_bad++;
          if (busy !== 1'b1 || tx_done !== 1'b0) mon_busy_bad++;
          if (mon_c % FR == FR - 1) begin
            check($sformatf("frame %0d bad cycles", mon_c / FR), mon_bad, 0);
            mon_bad = 0;
          end
          mon_c++;
        end else begin
          check("busy/done bad cycles in block", mon_busy_bad, 0);
          check("done cycle {tx_out,busy,tx_done}", {tx_out, busy, tx_done}, 3'b101);
          mon_active = 1'b0;
        end
      end else begin
        check("idle {tx_out,busy,tx_done}", {tx_out, busy, tx_done}, 3'b100);
      end
    end
  end

  task automatic send(input logic [63:0] d);
    data_in  = d;
    tx_start = 1'b1;
    q.push_back('{d, cyc + 1});
    @(negedge clk);
    tx_start = 1'b0;
    data_in  = ~d;
  endtask

  task automatic wait_done();
    int n = 0;
    while (tx_done !== 1'b1 && n < BLK + 100) begin
      @(negedge clk);
      n++;
    end
    check("tx_done arrives", tx_done, 1'b1);
  endtask

  initial begin : stimulus
    logic [63:0] d;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);

    send(64'h0123_4567_89AB_CDEF);
    wait_done();
    repeat (5) @(negedge clk);

    // Requests during an active block must be dropped, not queued or resampled.
    send(64'hFEDC_BA98_7654_3210);
    repeat (50) @(negedge clk);
    data_in  = '1;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (849) @(negedge clk);
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_done();
    repeat (10) @(negedge clk);

    // Abort mid data bit (line low there) with an asynchronous reset.
    send(64'h1122_3344_5566_8877);
    repeat (300) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("reset tx_out", tx_out, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset tx_done", tx_done, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    send(64'h0000_0000_0000_0007);
    wait_done();
    @(negedge clk);
    send(64'h0);
    wait_done();

    // tx_start raised in the DONE cycle and held: ignored there, taken in the following IDLE cycle.
    for (int i = 0; i < 10; i++) begin
      d        = {$urandom, $urandom};
      data_in  = d;
      tx_start = 1'b1;
      q.push_back('{d, cyc + 2});
      repeat (2) @(negedge clk);
      tx_start = 1'b0;
      data_in  = ~d;
      wait_done();
    end

    repeat (20) @(negedge clk);
    check("expected blocks left", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
